// File: rtl/alarm_ring_controller_pkg.sv
// Shared types for the alarm ring controller: session state encoding and edge helper.
`timescale 1ns/1ps
package alarm_ring_controller_pkg;

  typedef enum logic [1:0] {
    RING_IDLE   = 2'd0,
    RING_ACTIVE = 2'd1,
    RING_SNOOZE = 2'd2
  } ring_state_e;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/alarm_ring_controller_sec_countdown.sv
// Seconds down-counter; load beats tick, and the count never steps below 1 on its own.
`timescale 1ns/1ps
module sec_countdown #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (tick && (count > CNT_W'(1)))
      count <= count - CNT_W'(1);
  end

  assign last = (count == CNT_W'(1)) & tick;

endmodule

// File: rtl/alarm_ring_controller.sv
// Turns the alarm match level into a ring / snooze / dismiss session driving a beeping buzzer.
`timescale 1ns/1ps
module alarm_ring_controller
  import alarm_ring_controller_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3,
  parameter int unsigned CNT_W       = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             enable,
  input  logic             match,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [1:0]       snooze_count,
  output logic [CNT_W-1:0] remaining
);

  ring_state_e      state, state_n;
  logic [1:0]       sc, sc_n;
  logic             phase, phase_n;
  logic             match_r, match_d, snooze_r, snooze_d, stop_r, stop_d;
  logic             match_ev, snooze_ev, stop_ev;
  logic             cnt_load, cnt_last;
  logic [CNT_W-1:0] cnt_val, count;

  // Inputs are captured first, so events fire one clk after the level rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_r  <= 1'b0;
      match_d  <= 1'b0;
      snooze_r <= 1'b0;
      snooze_d <= 1'b0;
      stop_r   <= 1'b0;
      stop_d   <= 1'b0;
    end else begin
      match_r  <= match;
      match_d  <= match_r;
      snooze_r <= snooze_btn;
      snooze_d <= snooze_r;
      stop_r   <= stop_btn;
      stop_d   <= stop_r;
    end
  end

  assign match_ev  = rise(match_r, match_d);
  assign snooze_ev = rise(snooze_r, snooze_d);
  assign stop_ev   = rise(stop_r, stop_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RING_IDLE;
      sc    <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    phase_n  = phase;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (!enable) begin
      state_n  = RING_IDLE;
      sc_n     = '0;
      phase_n  = 1'b0;
      cnt_load = 1'b1;
    end else begin
      unique case (state)
        RING_IDLE: begin
          if (match_ev) begin
            state_n  = RING_ACTIVE;
            phase_n  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(RING_SECS);
          end
        end
        RING_ACTIVE: begin
          if (stop_ev) begin
            state_n  = RING_IDLE;
            sc_n     = '0;
            phase_n  = 1'b0;
            cnt_load = 1'b1;
          end else if (snooze_ev && (sc < 2'(MAX_SNOOZE))) begin
            state_n  = RING_SNOOZE;
            sc_n     = sc + 2'd1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(SNOOZE_SECS);
          end else if (tick_1hz) begin
            phase_n = ~phase;
            if (cnt_last) begin
              state_n  = RING_IDLE;
              sc_n     = '0;
              cnt_load = 1'b1;
            end
          end
        end
        RING_SNOOZE: begin
          if (stop_ev) begin
            state_n  = RING_IDLE;
            sc_n     = '0;
            phase_n  = 1'b0;
            cnt_load = 1'b1;
          end else if (cnt_last) begin
            state_n  = RING_ACTIVE;
            phase_n  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(RING_SECS);
          end
        end
        default: begin
          state_n  = RING_IDLE;
          sc_n     = '0;
          cnt_load = 1'b1;
        end
      endcase
    end
  end

  sec_countdown #(.CNT_W(CNT_W)) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (tick_1hz & (state != RING_IDLE)),
    .count    (count),
    .last     (cnt_last)
  );

  assign ringing      = (state == RING_ACTIVE);
  assign snoozing     = (state == RING_SNOOZE);
  assign buzzer       = ringing & phase;
  assign snooze_count = sc;
  assign remaining    = (state == RING_IDLE) ? '0 : count;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller with hand-computed expectations.
`timescale 1ns/1ps
module tb_alarm_ring_controller;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, enable, match, snooze_btn, stop_btn;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_count;
  logic [8:0] remaining;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  alarm_ring_controller #(
    .RING_SECS(60), .SNOOZE_SECS(300), .MAX_SNOOZE(3), .CNT_W(9)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .enable(enable),
    .match(match), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_count(snooze_count), .remaining(remaining)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int unsigned n);
    tick_1hz = 1'b1;
    cyc(n);
    tick_1hz = 1'b0;
  endtask

  task automatic start_session();
    match = 1'b1;
    cyc(2);
    match = 1'b0;
    cyc(1);
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    cyc(2);
    snooze_btn = 1'b0;
    cyc(1);
  endtask

  task automatic press_stop();
    stop_btn = 1'b1;
    cyc(2);
    stop_btn = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; enable = 1'b0; match = 1'b0;
    snooze_btn = 1'b0; stop_btn = 1'b0;
    cyc(3);
    chk("rst_ringing", {31'd0, ringing}, 32'd0);
    chk("rst_buzzer", {31'd0, buzzer}, 32'd0);
    chk("rst_remaining", {23'd0, remaining}, 32'd0);
    chk("rst_count", {30'd0, snooze_count}, 32'd0);
    reset = 1'b0;
    cyc(1);

    // First session: event one clk after capture, ringing the clk after that.
    enable = 1'b1;
    match = 1'b1;
    cyc(1);
    chk("ring_latency", {31'd0, ringing}, 32'd0);
    cyc(1);
    chk("ring_start", {31'd0, ringing}, 32'd1);
    chk("ring_rem60", {23'd0, remaining}, 32'd60);
    chk("ring_buz1", {31'd0, buzzer}, 32'd1);
    cyc(3);
    match = 1'b0;
    cyc(2);
    chk("match_held_rem", {23'd0, remaining}, 32'd60);
    ticks(1);
    chk("tick1_buz", {31'd0, buzzer}, 32'd0);
    chk("tick1_rem", {23'd0, remaining}, 32'd59);
    ticks(1);
    chk("tick2_buz", {31'd0, buzzer}, 32'd1);
    ticks(57);
    chk("tick59_rem", {23'd0, remaining}, 32'd1);
    chk("tick59_buz", {31'd0, buzzer}, 32'd0);
    chk("tick59_ring", {31'd0, ringing}, 32'd1);
    ticks(1);
    chk("timeout_ring", {31'd0, ringing}, 32'd0);
    chk("timeout_rem", {23'd0, remaining}, 32'd0);
    chk("timeout_cnt", {30'd0, snooze_count}, 32'd0);

    // Snooze at 42, then return to ringing after 300 ticks.
    start_session();
    ticks(18);
    chk("pre_snz_rem", {23'd0, remaining}, 32'd42);
    press_snooze();
    chk("snz1_state", {31'd0, snoozing}, 32'd1);
    chk("snz1_rem", {23'd0, remaining}, 32'd300);
    chk("snz1_cnt", {30'd0, snooze_count}, 32'd1);
    chk("snz1_buz", {31'd0, buzzer}, 32'd0);
    ticks(299);
    chk("snz1_last", {23'd0, remaining}, 32'd1);
    ticks(1);
    chk("resume_ring", {31'd0, ringing}, 32'd1);
    chk("resume_rem", {23'd0, remaining}, 32'd60);
    chk("resume_buz", {31'd0, buzzer}, 32'd1);
    press_snooze();
    ticks(300);
    press_snooze();
    chk("snz3_cnt", {30'd0, snooze_count}, 32'd3);
    ticks(300);
    press_snooze();
    chk("snz4_ring", {31'd0, ringing}, 32'd1);
    chk("snz4_cnt", {30'd0, snooze_count}, 32'd3);
    chk("snz4_rem", {23'd0, remaining}, 32'd60);
    press_stop();
    chk("stop_ring", {31'd0, ringing}, 32'd0);
    chk("stop_cnt", {30'd0, snooze_count}, 32'd0);
    chk("stop_rem", {23'd0, remaining}, 32'd0);

    // Snooze event coinciding with the final tick.
    start_session();
    ticks(59);
    chk("final_rem", {23'd0, remaining}, 32'd1);
    snooze_btn = 1'b1;
    cyc(1);
    ticks(1);
    chk("snz_vs_tick", {31'd0, snoozing}, 32'd1);
    chk("snz_vs_tick_rem", {23'd0, remaining}, 32'd300);
    snooze_btn = 1'b0;
    cyc(1);
    ticks(300);
    chk("back_ring", {31'd0, ringing}, 32'd1);
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    cyc(2);
    chk("stop_vs_snz_ring", {31'd0, ringing}, 32'd0);
    chk("stop_vs_snz_snz", {31'd0, snoozing}, 32'd0);
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    cyc(2);

    // Disarm during snooze, then no session while disarmed.
    start_session();
    press_snooze();
    chk("dis_pre", {31'd0, snoozing}, 32'd1);
    enable = 1'b0;
    cyc(1);
    chk("dis_snz", {31'd0, snoozing}, 32'd0);
    chk("dis_rem", {23'd0, remaining}, 32'd0);
    chk("dis_cnt", {30'd0, snooze_count}, 32'd0);
    match = 1'b1;
    cyc(3);
    chk("dis_match", {31'd0, ringing}, 32'd0);
    match = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(2);
    chk("rearm_idle", {31'd0, ringing}, 32'd0);

    // Async reset mid-ring with match held high.
    match = 1'b1;
    cyc(2);
    chk("rst2_ring", {31'd0, ringing}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_ring", {31'd0, ringing}, 32'd0);
    chk("async_buz", {31'd0, buzzer}, 32'd0);
    chk("async_rem", {23'd0, remaining}, 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("post_rst1", {31'd0, ringing}, 32'd0);
    cyc(1);
    chk("post_rst2", {31'd0, ringing}, 32'd1);
    chk("post_rst2_rem", {23'd0, remaining}, 32'd60);
    match = 1'b0;

    // Held snooze button yields one snooze only.
    snooze_btn = 1'b1;
    cyc(5);
    chk("hold_snz", {31'd0, snoozing}, 32'd1);
    chk("hold_cnt", {30'd0, snooze_count}, 32'd1);
    ticks(300);
    cyc(3);
    chk("hold_ring", {31'd0, ringing}, 32'd1);
    chk("hold_cnt2", {30'd0, snooze_count}, 32'd1);
    snooze_btn = 1'b0;
    press_stop();
    chk("end_idle", {31'd0, ringing}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
